// File: rtl/boot_copy_engine_pkg.sv
// Shared types and constants for the flash-to-SRAM boot copier.
package boot_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFrd,
        StHdr,
        StSwr,
        StChk,
        StDone,
        StErr
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_COUNT   = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [1:0] HDR_DST  = 2'd0;
    localparam logic [1:0] HDR_CNT  = 2'd1;
    localparam logic [1:0] HDR_CSUM = 2'd2;
    localparam logic [1:0] HDR_RSV  = 2'd3;

endpackage

// File: rtl/boot_copy_engine_if.sv
// Flash read port and SRAM write port of the boot copier.
interface boot_copy_engine_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned FLASH_AW = 25,
    parameter int unsigned SRAM_AW  = 22
);
    logic                flash_cen;
    logic                flash_oen;
    logic [FLASH_AW-1:0] flash_a;
    logic [DATA_W-1:0]   flash_dq;
    logic                flash_rdybsyn;
    logic                sram_cen;
    logic                sram_wen;
    logic [SRAM_AW-1:0]  sram_a;
    logic [DATA_W-1:0]   sram_dout;
    logic                sram_waitn;

    modport master (
        output flash_cen, flash_oen, flash_a,
        input  flash_dq, flash_rdybsyn,
        output sram_cen, sram_wen, sram_a, sram_dout,
        input  sram_waitn
    );

    modport slave (
        input  flash_cen, flash_oen, flash_a,
        output flash_dq, flash_rdybsyn,
        input  sram_cen, sram_wen, sram_a, sram_dout,
        output sram_waitn
    );
endinterface

// File: rtl/boot_copy_engine_flash_read_timer.sv
// Counts flash wait states, then strobes sample on the first ready cycle.
module flash_read_timer #(
    parameter int unsigned FLASH_WAIT = 3
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic en,
    input  logic rdy,
    output logic sample
);
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q != 4'(FLASH_WAIT)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    assign sample = en && (cnt_q == 4'(FLASH_WAIT)) && rdy;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/boot_copy_engine.sv
// Boot copier: reads a 4-word flash header, copies the payload to SRAM,
// optionally verifies the checksum, then releases the CPU via start.
module boot_copy_engine
    import boot_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned FLASH_AW     = 25,
    parameter int unsigned SRAM_AW      = 22,
    parameter int unsigned FLASH_WAIT   = 3,
    parameter int unsigned MAX_WORDS    = 4096,
    parameter bit          CHECK_EN     = 1'b1,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                go,
    input  logic [FLASH_AW-1:0] flash_base,
    boot_copy_engine_if.master  bus,
    output logic                busy,
    output logic                start,
    output logic                err,
    output logic [1:0]          err_code,
    output logic [SRAM_AW-1:0]  words_done
);
    localparam int unsigned ToW = (WAIT_TIMEOUT < 1) ? 1 : $clog2(WAIT_TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [FLASH_AW-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [1:0]          hidx_q, hidx_d;
    logic                hdr_q, hdr_d;
    logic [SRAM_AW-1:0]  dst_q, dst_d;
    logic [SRAM_AW-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0]   csum_q, csum_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic [SRAM_AW-1:0]  idx_q, idx_d;
    logic [ToW-1:0]      to_q, to_d;
    logic [1:0]          err_code_q, err_code_d;
    logic                go_low_q, go_low_d;
    logic                sample;
    logic                launch;

    flash_read_timer #(
        .FLASH_WAIT(FLASH_WAIT)
    ) u_timer (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .en     (state_q == StFrd),
        .rdy    (bus.flash_rdybsyn),
        .sample (sample)
    );

    // Restart from DONE/ERR needs go seen low first, so a held go cannot loop.
    assign launch = go && ((state_q == StIdle) ||
                    (((state_q == StDone) || (state_q == StErr)) && go_low_q));

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        word_d     = word_q;
        hidx_d     = hidx_q;
        hdr_d      = hdr_q;
        dst_d      = dst_q;
        cnt_d      = cnt_q;
        csum_d     = csum_q;
        sum_d      = sum_q;
        idx_d      = idx_q;
        to_d       = to_q;
        err_code_d = err_code_q;
        go_low_d   = go_low_q;

        unique case (state_q)
            StIdle: ;
            StFrd: begin
                if (sample) begin
                    word_d  = bus.flash_dq;
                    ptr_d   = ptr_q + FLASH_AW'(1);
                    state_d = hdr_q ? StHdr : StSwr;
                end
            end
            StHdr: begin
                hidx_d  = hidx_q + 2'd1;
                state_d = StFrd;
                unique case (hidx_q)
                    HDR_DST: dst_d = word_q[SRAM_AW-1:0];
                    HDR_CNT: begin
                        cnt_d = word_q[SRAM_AW-1:0];
                        if (word_q > DATA_W'(MAX_WORDS)) begin
                            state_d    = StErr;
                            err_code_d = ERR_COUNT;
                        end
                    end
                    HDR_CSUM: csum_d = word_q;
                    HDR_RSV: begin
                        hdr_d = 1'b0;
                        if (cnt_q == '0) begin
                            state_d = StDone;
                        end
                    end
                endcase
            end
            StSwr: begin
                if (bus.sram_waitn) begin
                    idx_d = idx_q + SRAM_AW'(1);
                    sum_d = sum_q + word_q;
                    to_d  = '0;
                    if ((idx_q + SRAM_AW'(1)) == cnt_q) begin
                        state_d = CHECK_EN ? StChk : StDone;
                    end else begin
                        state_d = StFrd;
                    end
                end else if (to_q == ToW'(WAIT_TIMEOUT)) begin
                    state_d    = StErr;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    to_d = to_q + ToW'(1);
                end
            end
            StChk: begin
                if (sum_q == csum_q) begin
                    state_d = StDone;
                end else begin
                    state_d    = StErr;
                    err_code_d = ERR_CSUM;
                end
            end
            StDone, StErr: begin
                if (!go) begin
                    go_low_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (launch) begin
            state_d    = StFrd;
            ptr_d      = flash_base;
            idx_d      = '0;
            sum_d      = '0;
            hidx_d     = HDR_DST;
            hdr_d      = 1'b1;
            to_d       = '0;
            err_code_d = ERR_NONE;
            go_low_d   = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            word_q     <= '0;
            hidx_q     <= '0;
            hdr_q      <= 1'b0;
            dst_q      <= '0;
            cnt_q      <= '0;
            csum_q     <= '0;
            sum_q      <= '0;
            idx_q      <= '0;
            to_q       <= '0;
            err_code_q <= ERR_NONE;
            go_low_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            word_q     <= word_d;
            hidx_q     <= hidx_d;
            hdr_q      <= hdr_d;
            dst_q      <= dst_d;
            cnt_q      <= cnt_d;
            csum_q     <= csum_d;
            sum_q      <= sum_d;
            idx_q      <= idx_d;
            to_q       <= to_d;
            err_code_q <= err_code_d;
            go_low_q   <= go_low_d;
        end
    end

    assign bus.flash_cen = (state_q != StFrd);
    assign bus.flash_oen = (state_q != StFrd);
    assign bus.flash_a   = ptr_q;
    assign bus.sram_cen  = (state_q != StSwr);
    assign bus.sram_wen  = (state_q != StSwr);
    assign bus.sram_a    = dst_q + idx_q;
    assign bus.sram_dout = word_q;

    assign busy       = !(state_q inside {StIdle, StDone, StErr});
    assign start      = (state_q == StDone);
    assign err        = (state_q == StErr);
    assign err_code   = err_code_q;
    assign words_done = idx_q;
endmodule

// File: tb/tb_boot_copy_engine.sv
// Directed bench for boot_copy_engine with behavioural flash and SRAM models.
module tb_boot_copy_engine;
    import boot_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        go = 1'b0;
    logic [24:0] flash_base = '0;
    logic        busy, start, err;
    logic [1:0]  err_code;
    logic [21:0] words_done;

    boot_copy_engine_if #(.DATA_W(32), .FLASH_AW(25), .SRAM_AW(22)) bus ();

    boot_copy_engine #(
        .DATA_W(32), .FLASH_AW(25), .SRAM_AW(22), .FLASH_WAIT(3),
        .MAX_WORDS(4096), .CHECK_EN(1'b1), .WAIT_TIMEOUT(255)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .go        (go),
        .flash_base(flash_base),
        .bus       (bus),
        .busy      (busy),
        .start     (start),
        .err       (err),
        .err_code  (err_code),
        .words_done(words_done)
    );

    always #5 sys_clk = ~sys_clk;

    logic [31:0] fmem [16];
    logic [31:0] pay [5] = '{32'h34090001, 32'h340a0002, 32'h340c0004, 32'h340d0005,
                             32'h014b4820};
    logic        rdy = 1'b1;
    logic        waitn = 1'b1;
    int          rdy_idx = -1, rdy_len = 0;
    int          stall_idx = -1, stall_len = 0;
    int          oen_run = 0, wen_run = 0;
    int          oen_runs[$], wen_runs[$];
    logic [31:0] wr_addr[$], wr_data[$];
    int          errors = 0, checks = 0;

    assign bus.flash_dq      = fmem[4'(bus.flash_a - flash_base)];
    assign bus.flash_rdybsyn = rdy;
    assign bus.sram_waitn    = waitn;

    // Drives ready/wait for the following rising edge and logs run lengths and writes.
    always @(negedge sys_clk) begin
        if (!bus.flash_oen) begin
            oen_run <= oen_run + 1;
            rdy <= !((oen_runs.size() == rdy_idx) && (oen_run + 1 <= rdy_len));
        end else begin
            if (oen_run != 0) oen_runs.push_back(oen_run);
            oen_run <= 0;
            rdy <= 1'b1;
        end
        if (!bus.sram_wen) begin
            wen_run <= wen_run + 1;
            if ((wr_data.size() == stall_idx) && (wen_run + 1 <= stall_len)) begin
                waitn <= 1'b0;
            end else begin
                waitn <= 1'b1;
                wr_addr.push_back(32'(bus.sram_a));
                wr_data.push_back(bus.sram_dout);
            end
        end else begin
            if (wen_run != 0) wen_runs.push_back(wen_run);
            wen_run <= 0;
            waitn <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_image(input logic [24:0] base, input logic [31:0] cnt,
                              input logic [31:0] csum);
        flash_base = base;
        fmem[0] = 32'h0000_0C00;
        fmem[1] = cnt;
        fmem[2] = csum;
        fmem[3] = 32'h0;
        for (int i = 0; i < 5; i++) fmem[4+i] = pay[i];
    endtask

    task automatic go_and_wait(input string tag);
        @(negedge sys_clk) go = 1'b1;
        @(negedge sys_clk) go = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (start || err) break;
            @(negedge sys_clk);
        end
        chk({tag, "_finished"}, 64'(start || err), 64'd1);
        @(negedge sys_clk);
    endtask

    task automatic chk_payload(input string tag, input int wb);
        for (int i = 0; i < 5; i++) begin
            chk({tag, "_addr"}, 64'(wr_addr[wb+i]), 64'(32'h0C00 + i));
            chk({tag, "_data"}, 64'(wr_data[wb+i]), 64'(pay[i]));
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb, rb, eb;
        for (int i = 0; i < 16; i++) fmem[i] = '0;
        repeat (2) @(negedge sys_clk);
        chk("rst_flash_cen", 64'(bus.flash_cen), 64'd1);
        chk("rst_flash_oen", 64'(bus.flash_oen), 64'd1);
        chk("rst_sram_cen", 64'(bus.sram_cen), 64'd1);
        chk("rst_sram_wen", 64'(bus.sram_wen), 64'd1);
        chk("rst_flash_a", 64'(bus.flash_a), 64'd0);
        chk("rst_sram_a", 64'(bus.sram_a), 64'd0);
        chk("rst_sram_dout", 64'(bus.sram_dout), 64'd0);
        chk("rst_status", 64'({busy, start, err, err_code}), 64'd0);
        chk("rst_words_done", 64'(words_done), 64'd0);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("idle_no_busy", 64'(busy), 64'd0);

        // Normal copy
        load_image(25'h100, 32'd5, 32'hD177482C);
        wb = wr_data.size(); rb = oen_runs.size();
        go_and_wait("normal");
        chk("normal_start", 64'(start), 64'd1);
        chk("normal_err", 64'(err), 64'd0);
        chk("normal_code", 64'(err_code), 64'(ERR_NONE));
        chk("normal_words", 64'(words_done), 64'd5);
        chk("normal_nwr", 64'(wr_data.size() - wb), 64'd5);
        chk("normal_nrd", 64'(oen_runs.size() - rb), 64'd9);
        chk("normal_oen_len", 64'(oen_runs[rb]), 64'd4);
        chk_payload("normal", wb);

        // Restart after DONE repeats the copy
        wb = wr_data.size();
        go_and_wait("rego");
        chk("rego_start", 64'(start), 64'd1);
        chk("rego_nwr", 64'(wr_data.size() - wb), 64'd5);
        chk_payload("rego", wb);

        // Checksum mismatch
        load_image(25'h100, 32'd5, 32'h0);
        wb = wr_data.size();
        go_and_wait("csum");
        chk("csum_err", 64'(err), 64'd1);
        chk("csum_code", 64'(err_code), 64'(ERR_CSUM));
        chk("csum_start", 64'(start), 64'd0);
        chk("csum_nwr", 64'(wr_data.size() - wb), 64'd5);

        // Oversize count
        load_image(25'h100, 32'd4097, 32'hD177482C);
        wb = wr_data.size(); rb = oen_runs.size(); eb = wen_runs.size();
        go_and_wait("over");
        chk("over_code", 64'(err_code), 64'(ERR_COUNT));
        chk("over_err", 64'(err), 64'd1);
        chk("over_nwr", 64'(wr_data.size() - wb), 64'd0);
        chk("over_wen_runs", 64'(wen_runs.size() - eb), 64'd0);
        chk("over_nrd", 64'(oen_runs.size() - rb), 64'd2);

        // SRAM stall of 10 cycles on word 2
        load_image(25'h100, 32'd5, 32'hD177482C);
        wb = wr_data.size(); eb = wen_runs.size();
        stall_idx = wb + 2; stall_len = 10;
        go_and_wait("stall");
        chk("stall_start", 64'(start), 64'd1);
        chk("stall_wen_len", 64'(wen_runs[eb+2]), 64'd11);
        chk("stall_wen_len1", 64'(wen_runs[eb+1]), 64'd1);
        chk_payload("stall", wb);

        // SRAM stall past the timeout
        wb = wr_data.size(); eb = wen_runs.size();
        stall_idx = wb + 2; stall_len = 300;
        go_and_wait("tmo");
        chk("tmo_code", 64'(err_code), 64'(ERR_TIMEOUT));
        chk("tmo_err", 64'(err), 64'd1);
        chk("tmo_wen_len", 64'(wen_runs[eb+2]), 64'd256);
        chk("tmo_words", 64'(words_done), 64'd2);
        stall_idx = -1; stall_len = 0;

        // Flash busy on word 0, header straddling the flash address wrap
        load_image(25'h1FFFFFE, 32'd5, 32'hD177482C);
        wb = wr_data.size(); rb = oen_runs.size();
        rdy_idx = rb; rdy_len = 7;
        go_and_wait("fbusy");
        chk("fbusy_oen_len", 64'(oen_runs[rb]), 64'd8);
        chk("fbusy_oen_len1", 64'(oen_runs[rb+1]), 64'd4);
        chk("fbusy_start", 64'(start), 64'd1);
        chk_payload("fbusy", wb);
        rdy_idx = -1; rdy_len = 0;

        // Empty image
        load_image(25'h100, 32'd0, 32'h12345678);
        wb = wr_data.size(); rb = oen_runs.size();
        go_and_wait("zero");
        chk("zero_start", 64'(start), 64'd1);
        chk("zero_nwr", 64'(wr_data.size() - wb), 64'd0);
        chk("zero_nrd", 64'(oen_runs.size() - rb), 64'd4);
        chk("zero_words", 64'(words_done), 64'd0);

        // Reset while stalled in the SRAM write
        load_image(25'h100, 32'd5, 32'hD177482C);
        stall_idx = wr_data.size(); stall_len = 1000;
        @(negedge sys_clk) go = 1'b1;
        @(negedge sys_clk) go = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!bus.sram_wen) break;
            @(negedge sys_clk);
        end
        chk("mid_in_swr", 64'(bus.sram_wen), 64'd0);
        repeat (3) @(negedge sys_clk);
        chk("mid_busy", 64'(busy), 64'd1);
        sys_rst = 1'b1;
        #1;
        chk("mid_sram_wen", 64'(bus.sram_wen), 64'd1);
        chk("mid_sram_cen", 64'(bus.sram_cen), 64'd1);
        chk("mid_flash_cen", 64'(bus.flash_cen), 64'd1);
        chk("mid_addrs", 64'({bus.flash_a, bus.sram_a}), 64'd0);
        chk("mid_dout", 64'(bus.sram_dout), 64'd0);
        chk("mid_status", 64'({busy, start, err, err_code, words_done}), 64'd0);
        @(negedge sys_clk) sys_rst = 1'b0;
        stall_idx = -1; stall_len = 0;
        @(negedge sys_clk);

        // Recovery after reset
        wb = wr_data.size();
        go_and_wait("post");
        chk("post_start", 64'(start), 64'd1);
        chk_payload("post", wb);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
